// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states, drives the
// datapath selects and strobes, waits on a variable-latency memory, flags
// undecodable opcodes and counts retired instructions.
module mips_multicycle_control #(
    parameter bit MEM_HS       = 1'b1,
    parameter bit EN_BNE       = 1'b1,
    parameter bit EN_IMM_LOGIC = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             BranchNe,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUOp,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal_op,
    output logic             retire,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_rdy;

    // Without the handshake every memory access completes in one cycle.
    assign mem_rdy = MEM_HS ? mem_ready : 1'b1;

    // Dispatch target for an opcode; S_FETCH means the opcode is not decodable.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:               nxt = S_MEMADR;
            OP_RTYPE:                   nxt = S_RTEXEC;
            OP_BEQ:                     nxt = S_BRANCH;
            OP_BNE:                     nxt = EN_BNE ? S_BRANCH : S_FETCH;
            OP_ADDI:                    nxt = S_IEXEC;
            OP_SLTI, OP_ANDI, OP_ORI:   nxt = EN_IMM_LOGIC ? S_IEXEC : S_FETCH;
            OP_J:                       nxt = S_JUMP;
            default:                    nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

    // Next-state, opcode latch, illegal-opcode pulse and retire counter.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = 1'b0;
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, retire};
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d  = opcode;
                state_d   = decode_next(opcode);
                // PC was already advanced in FETCH, so just refetch and flag it.
                illegal_d = (decode_next(opcode) == S_FETCH);
            end
            S_MEMADR: state_d = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_RTEXEC: state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode of the datapath controls; reset silences every output.
    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ExtOp      = 1'b0;
        ALUOp      = ALU_ADD;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        retire     = 1'b0;
        illegal_op = illegal_q;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_rdy;
            end
            S_RTEXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSrc    = 2'b01;
                Branch   = (opcode_q == OP_BEQ);
                BranchNe = (opcode_q != OP_BEQ);
                retire   = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode_q)
                    OP_SLTI: ALUOp = ALU_SLT;
                    OP_ANDI: begin ALUOp = ALU_AND; ExtOp = 1'b1; end
                    OP_ORI:  begin ALUOp = ALU_OR;  ExtOp = 1'b1; end
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_IWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            BranchNe   = 1'b0;
            PCSrc      = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ExtOp      = 1'b0;
            ALUOp      = ALU_ADD;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            retire     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // State, latched opcode, illegal flag and retire count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= 6'b000000;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule
